// File: rtl/prog_data_memory_pkg.sv
// Shared constants and state encoding for the unified program/data memory.
package cpu_mem_pkg;

    localparam int unsigned MEM_ADDR_W  = 8;
    localparam int unsigned MEM_DATA_W  = 8;
    localparam int unsigned INSTR_BYTES = 2;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } mem_state_e;

endpackage

// File: rtl/prog_data_memory_if.sv
// Bus bundle between the SimpleCPU core (master) and the unified memory (slave).
interface prog_data_memory_if
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = MEM_ADDR_W,
    parameter int unsigned DATA_W  = MEM_DATA_W,
    parameter int unsigned N_BYTES = INSTR_BYTES
);

    logic                        ready;
    logic                        prog_we;
    logic [ADDR_W-1:0]           prog_addr;
    logic [DATA_W-1:0]           prog_din;
    logic                        if_req;
    logic [ADDR_W-1:0]           if_addr;
    logic                        if_valid;
    logic [N_BYTES*DATA_W-1:0]   if_ins;
    logic                        d_req;
    logic                        d_we;
    logic [ADDR_W-1:0]           d_addr;
    logic [DATA_W-1:0]           d_din;
    logic                        d_gnt;
    logic                        d_valid;
    logic [DATA_W-1:0]           d_dout;

    modport master (
        input  ready, if_valid, if_ins, d_gnt, d_valid, d_dout,
        output prog_we, prog_addr, prog_din, if_req, if_addr,
               d_req, d_we, d_addr, d_din
    );

    modport slave (
        output ready, if_valid, if_ins, d_gnt, d_valid, d_dout,
        input  prog_we, prog_addr, prog_din, if_req, if_addr,
               d_req, d_we, d_addr, d_din
    );

endinterface

// File: rtl/prog_data_memory_init_seq.sv
// Reset-time clear sequencer: walks every address once, then parks in READY.
module mem_init_seq
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = MEM_ADDR_W,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    mem_state_e        state_q;
    logic [ADDR_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    // Without clearing there is nothing to walk; leave after one cycle.
                    if (!CLEAR_ON_RESET || (cnt_q == LAST_ADDR)) begin
                        state_q <= ST_READY;
                    end
                end
                default: state_q <= ST_READY;
            endcase
        end
    end

    assign clr_we   = (state_q == ST_INIT) && CLEAR_ON_RESET;
    assign clr_addr = cnt_q;
    assign done     = (state_q == ST_READY);

endmodule

// File: rtl/prog_data_memory.sv
// Unified byte-addressed memory: fetch port, data port with grant, programming port, reset clear.
module prog_data_memory
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = MEM_ADDR_W,
    parameter int unsigned DATA_W         = MEM_DATA_W,
    parameter int unsigned N_BYTES        = INSTR_BYTES,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    prog_data_memory_if.slave   bus
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned INS_W = N_BYTES * DATA_W;

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              ready;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              if_valid_q;
    logic [INS_W-1:0]  if_ins_q;
    logic              d_valid_q;
    logic [DATA_W-1:0] d_dout_q;

    logic              d_gnt_c;
    logic              fetch_acc_c;
    logic              d_rd_acc_c;
    logic              d_wr_acc_c;
    logic              prog_acc_c;
    logic [INS_W-1:0]  ins_c;

    mem_init_seq #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_init_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .done     (ready)
    );

    assign d_gnt_c     = ready & ~bus.prog_we;
    assign prog_acc_c  = ready & bus.prog_we;
    assign fetch_acc_c = ready & bus.if_req;
    assign d_rd_acc_c  = bus.d_req & ~bus.d_we & d_gnt_c;
    assign d_wr_acc_c  = bus.d_req &  bus.d_we & d_gnt_c;

    // Little-endian gather; the address sum truncates so fetches wrap at the top.
    always_comb begin
        logic [ADDR_W-1:0] a;
        ins_c = '0;
        a     = '0;
        for (int k = 0; k < int'(N_BYTES); k++) begin
            a = ADDR_W'(bus.if_addr + ADDR_W'(k));
            ins_c[k*DATA_W +: DATA_W] = mem_q[a];
        end
    end

    // Single array write per cycle: clear, then programming, then granted data write.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (prog_acc_c) begin
            mem_q[bus.prog_addr] <= bus.prog_din;
        end else if (d_wr_acc_c) begin
            mem_q[bus.d_addr] <= bus.d_din;
        end
    end

    // Read ports sample the pre-edge array, giving read-before-write on collisions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if_valid_q <= 1'b0;
            if_ins_q   <= '0;
            d_valid_q  <= 1'b0;
            d_dout_q   <= '0;
        end else begin
            if_valid_q <= fetch_acc_c;
            d_valid_q  <= d_rd_acc_c;
            if (fetch_acc_c) begin
                if_ins_q <= ins_c;
            end
            if (d_rd_acc_c) begin
                d_dout_q <= mem_q[bus.d_addr];
            end
        end
    end

    assign bus.ready    = ready;
    assign bus.d_gnt    = d_gnt_c;
    assign bus.if_valid = if_valid_q;
    assign bus.if_ins   = if_ins_q;
    assign bus.d_valid  = d_valid_q;
    assign bus.d_dout   = d_dout_q;

endmodule

// File: tb/tb_prog_data_memory.sv
// Directed bench for prog_data_memory with clearing and non-clearing instances.
module tb_prog_data_memory;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_pass;
    int   n_chk;
    int   n_cyc;

    prog_data_memory_if #(.ADDR_W(8), .DATA_W(8), .N_BYTES(2)) bus_a ();
    prog_data_memory_if #(.ADDR_W(8), .DATA_W(8), .N_BYTES(2)) bus_b ();

    prog_data_memory #(.ADDR_W(8), .DATA_W(8), .N_BYTES(2), .CLEAR_ON_RESET(1'b1)) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    prog_data_memory #(.ADDR_W(8), .DATA_W(8), .N_BYTES(2), .CLEAR_ON_RESET(1'b0)) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready_a(output int n);
        n = 0;
        while (n < 400) begin
            tick();
            n++;
            if (bus_a.ready === 1'b1) break;
        end
    endtask

    task automatic prog_a(input logic [7:0] addr, input logic [7:0] din);
        bus_a.prog_we   = 1'b1;
        bus_a.prog_addr = addr;
        bus_a.prog_din  = din;
        tick();
        bus_a.prog_we   = 1'b0;
    endtask

    task automatic read_a(input logic [7:0] addr);
        bus_a.d_req  = 1'b1;
        bus_a.d_we   = 1'b0;
        bus_a.d_addr = addr;
        tick();
        bus_a.d_req  = 1'b0;
    endtask

    task automatic fetch_a(input logic [7:0] addr);
        bus_a.if_req  = 1'b1;
        bus_a.if_addr = addr;
        tick();
        bus_a.if_req  = 1'b0;
    endtask

    initial begin
        n_pass = 0;
        n_chk  = 0;
        rst_a  = 1'b0;
        rst_b  = 1'b0;
        {bus_a.prog_we, bus_a.if_req, bus_a.d_req, bus_a.d_we} = '0;
        {bus_a.prog_addr, bus_a.prog_din, bus_a.if_addr, bus_a.d_addr, bus_a.d_din} = '0;
        {bus_b.prog_we, bus_b.if_req, bus_b.d_req, bus_b.d_we} = '0;
        {bus_b.prog_addr, bus_b.prog_din, bus_b.if_addr, bus_b.d_addr, bus_b.d_din} = '0;
        tick();
        tick();

        // Reset state
        chk("rst_ready",    32'(bus_a.ready),    32'h0);
        chk("rst_if_valid", 32'(bus_a.if_valid), 32'h0);
        chk("rst_if_ins",   32'(bus_a.if_ins),   32'h0);
        chk("rst_d_valid",  32'(bus_a.d_valid),  32'h0);
        chk("rst_d_dout",   32'(bus_a.d_dout),   32'h0);

        rst_a = 1'b1;
        wait_ready_a(n_cyc);
        chk("init_len", 32'(n_cyc), 32'd256);

        // 1: programmed byte is cleared by a reset pulse
        prog_a(8'h10, 8'hAB);
        read_a(8'h10);
        chk("pre_clr_valid", 32'(bus_a.d_valid), 32'h1);
        chk("pre_clr_dout",  32'(bus_a.d_dout),  32'hAB);
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        chk("pulse_ready0", 32'(bus_a.ready), 32'h0);
        wait_ready_a(n_cyc);
        chk("reinit_len", 32'(n_cyc), 32'd256);
        read_a(8'h10);
        chk("clr_valid", 32'(bus_a.d_valid), 32'h1);
        chk("clr_dout",  32'(bus_a.d_dout),  32'h00);

        // 2: program + fetch, hold, wrap, back-to-back
        prog_a(8'h04, 8'h70);
        prog_a(8'h05, 8'h00);
        prog_a(8'hFF, 8'h11);
        prog_a(8'h00, 8'h22);
        fetch_a(8'h04);
        chk("fetch_valid", 32'(bus_a.if_valid), 32'h1);
        chk("fetch_ins",   32'(bus_a.if_ins),   32'h0070);
        tick();
        chk("hold_valid", 32'(bus_a.if_valid), 32'h0);
        chk("hold_ins",   32'(bus_a.if_ins),   32'h0070);
        fetch_a(8'hFF);
        chk("wrap_ins", 32'(bus_a.if_ins), 32'h2211);
        bus_a.if_req  = 1'b1;
        bus_a.if_addr = 8'h04;
        tick();
        chk("b2b0_valid", 32'(bus_a.if_valid), 32'h1);
        chk("b2b0_ins",   32'(bus_a.if_ins),   32'h0070);
        bus_a.if_addr = 8'hFF;
        tick();
        bus_a.if_req  = 1'b0;
        chk("b2b1_valid", 32'(bus_a.if_valid), 32'h1);
        chk("b2b1_ins",   32'(bus_a.if_ins),   32'h2211);

        // 3: programming write blocks the data port for that cycle
        bus_a.prog_we   = 1'b1;
        bus_a.prog_addr = 8'h20;
        bus_a.prog_din  = 8'hFF;
        bus_a.d_req     = 1'b1;
        bus_a.d_we      = 1'b1;
        bus_a.d_addr    = 8'h20;
        bus_a.d_din     = 8'h55;
        #1;
        chk("arb_gnt0", 32'(bus_a.d_gnt), 32'h0);
        tick();
        bus_a.prog_we = 1'b0;
        #1;
        chk("arb_gnt1", 32'(bus_a.d_gnt), 32'h1);
        tick();
        bus_a.d_req = 1'b0;
        bus_a.d_we  = 1'b0;
        read_a(8'h20);
        chk("arb_dout", 32'(bus_a.d_dout), 32'h55);

        // 4: same-cycle write and fetch return the old byte
        prog_a(8'h30, 8'h01);
        bus_a.d_req   = 1'b1;
        bus_a.d_we    = 1'b1;
        bus_a.d_addr  = 8'h30;
        bus_a.d_din   = 8'h02;
        bus_a.if_req  = 1'b1;
        bus_a.if_addr = 8'h30;
        tick();
        bus_a.d_req = 1'b0;
        bus_a.d_we  = 1'b0;
        chk("coll_old", 32'(bus_a.if_ins[7:0]), 32'h01);
        tick();
        bus_a.if_req = 1'b0;
        chk("coll_new", 32'(bus_a.if_ins[7:0]), 32'h02);

        // 5a: reset at INIT cycle 100 restarts the full clear
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        bus_a.d_req = 1'b1;
        bus_a.d_we  = 1'b0;
        bus_a.d_addr = 8'h20;
        #1;
        chk("init_gnt", 32'(bus_a.d_gnt), 32'h0);
        repeat (100) tick();
        bus_a.d_req = 1'b0;
        chk("init_no_valid", 32'(bus_a.d_valid), 32'h0);
        chk("init_ready0",   32'(bus_a.ready),   32'h0);
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        wait_ready_a(n_cyc);
        chk("midinit_len", 32'(n_cyc), 32'd256);

        // 5b: read granted as reset hits produces no valid pulse
        bus_a.d_req  = 1'b1;
        bus_a.d_we   = 1'b0;
        bus_a.d_addr = 8'h20;
        rst_a        = 1'b0;
        #1;
        chk("drop_gnt", 32'(bus_a.d_gnt), 32'h1);
        tick();
        bus_a.d_req = 1'b0;
        rst_a       = 1'b1;
        chk("drop_valid", 32'(bus_a.d_valid), 32'h0);
        tick();
        chk("drop_valid2", 32'(bus_a.d_valid), 32'h0);

        // 6: no-clear instance keeps contents, ready one cycle after reset
        chk("nc_ready0", 32'(bus_b.ready), 32'h0);
        rst_b = 1'b1;
        tick();
        chk("nc_ready1", 32'(bus_b.ready), 32'h1);
        bus_b.prog_we   = 1'b1;
        bus_b.prog_addr = 8'h50;
        bus_b.prog_din  = 8'h5A;
        tick();
        bus_b.prog_we = 1'b0;
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        chk("nc_rst_ready", 32'(bus_b.ready), 32'h0);
        tick();
        chk("nc_ready2", 32'(bus_b.ready), 32'h1);
        bus_b.d_req  = 1'b1;
        bus_b.d_we   = 1'b0;
        bus_b.d_addr = 8'h50;
        tick();
        bus_b.d_req = 1'b0;
        chk("nc_valid", 32'(bus_b.d_valid), 32'h1);
        chk("nc_keep",  32'(bus_b.d_dout),  32'h5A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
